// File: rtl/weight_load_sequencer_if.sv
// Weight source stream plus the three kernel weight streams.
// master: the sequencer side; slave: the DMA/kernel environment side.
interface weight_load_sequencer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] s_axis_wsrc_tdata;
  logic                  s_axis_wsrc_tvalid;
  logic                  s_axis_wsrc_tready;
  logic [DATA_WIDTH-1:0] filter_weights_tdata;
  logic                  filter_weights_tvalid;
  logic                  filter_weights_tready;
  logic [DATA_WIDTH-1:0] bias_stream_tdata;
  logic                  bias_stream_tvalid;
  logic                  bias_stream_tready;
  logic [DATA_WIDTH-1:0] normalization_params_tdata;
  logic                  normalization_params_tvalid;
  logic                  normalization_params_tready;

  modport master (
    input  s_axis_wsrc_tdata, s_axis_wsrc_tvalid,
    output s_axis_wsrc_tready,
    output filter_weights_tdata, filter_weights_tvalid,
    input  filter_weights_tready,
    output bias_stream_tdata, bias_stream_tvalid,
    input  bias_stream_tready,
    output normalization_params_tdata, normalization_params_tvalid,
    input  normalization_params_tready
  );

  modport slave (
    output s_axis_wsrc_tdata, s_axis_wsrc_tvalid,
    input  s_axis_wsrc_tready,
    input  filter_weights_tdata, filter_weights_tvalid,
    output filter_weights_tready,
    input  bias_stream_tdata, bias_stream_tvalid,
    output bias_stream_tready,
    input  normalization_params_tdata, normalization_params_tvalid,
    output normalization_params_tready
  );
endinterface

// File: rtl/weight_load_sequencer.sv
// Splits one packed weight stream into filter/bias/norm bursts per tile.
// Routing is purely combinational; only the segment FSM and counters are registered.
module weight_load_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int FILTER_LEN = 36,
  parameter int BIAS_LEN   = 4,
  parameter int NORM_LEN   = 8,
  parameter int TILE_W     = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TILE_W-1:0] num_tiles,
  output logic              busy,
  output logic              done,
  output logic [TILE_W-1:0] tile_idx,
  weight_load_sequencer_if.master wif
);

  localparam int MAX_FB  = (FILTER_LEN > BIAS_LEN) ? FILTER_LEN : BIAS_LEN;
  localparam int MAX_LEN = (MAX_FB > NORM_LEN) ? MAX_FB : NORM_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // Empty segments are never entered, so their "last" value is irrelevant.
  localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'((BIAS_LEN > 0) ? BIAS_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'((NORM_LEN > 0) ? NORM_LEN - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_FILTER, S_BIAS, S_NORM, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
  logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_WIDTH-1:0] src_data;
  logic   src_ready;
  logic   beat;
  logic   seg_last;
  logic   tile_end;
  state_e nxt_seg;

  assign src_data = wif.s_axis_wsrc_tdata;
  assign beat     = wif.s_axis_wsrc_tvalid & src_ready;

  // Destination data buses always mirror the source; tvalid qualifies them.
  assign wif.filter_weights_tdata       = src_data;
  assign wif.bias_stream_tdata          = src_data;
  assign wif.normalization_params_tdata = src_data;
  assign wif.s_axis_wsrc_tready         = src_ready;

  // Steer valid to the active segment and take ready back from it.
  always_comb begin
    wif.filter_weights_tvalid       = 1'b0;
    wif.bias_stream_tvalid          = 1'b0;
    wif.normalization_params_tvalid = 1'b0;
    src_ready                       = 1'b0;
    case (state_q)
      S_FILTER: begin
        wif.filter_weights_tvalid = wif.s_axis_wsrc_tvalid;
        src_ready                 = wif.filter_weights_tready;
      end
      S_BIAS: begin
        wif.bias_stream_tvalid = wif.s_axis_wsrc_tvalid;
        src_ready              = wif.bias_stream_tready;
      end
      S_NORM: begin
        wif.normalization_params_tvalid = wif.s_axis_wsrc_tvalid;
        src_ready                       = wif.normalization_params_tready;
      end
      default: ;
    endcase
  end

  // Per-segment last-beat decode and successor, skipping zero-length segments.
  always_comb begin
    seg_last = 1'b0;
    tile_end = 1'b0;
    nxt_seg  = S_FILTER;
    case (state_q)
      S_FILTER: begin
        seg_last = (beat_cnt_q == F_LAST);
        if (BIAS_LEN != 0)      nxt_seg  = S_BIAS;
        else if (NORM_LEN != 0) nxt_seg  = S_NORM;
        else                    tile_end = 1'b1;
      end
      S_BIAS: begin
        seg_last = (beat_cnt_q == B_LAST);
        if (NORM_LEN != 0) nxt_seg  = S_NORM;
        else               tile_end = 1'b1;
      end
      S_NORM: begin
        seg_last = (beat_cnt_q == N_LAST);
        tile_end = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state: run control, beat counting, tile stepping.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    tile_idx_d  = tile_idx_q;
    num_tiles_d = num_tiles_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_tiles_d = num_tiles;
          tile_idx_d  = '0;
          beat_cnt_d  = '0;
          state_d     = (num_tiles == '0) ? S_DONE : S_FILTER;
        end
      end
      S_FILTER, S_BIAS, S_NORM: begin
        if (abort) begin
          // Abort beat still moves on the wire but is deliberately not counted.
          state_d    = S_IDLE;
          beat_cnt_d = '0;
        end else if (beat) begin
          if (seg_last) begin
            beat_cnt_d = '0;
            if (!tile_end) begin
              state_d = nxt_seg;
            end else if (tile_idx_q == num_tiles_q - TILE_W'(1)) begin
              state_d = S_DONE;
            end else begin
              tile_idx_d = tile_idx_q + TILE_W'(1);
              state_d    = S_FILTER;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FILTER) || (state_d == S_BIAS) || (state_d == S_NORM);
    done_d = (state_d == S_DONE);
  end

  // State and registered status outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      tile_idx_q  <= '0;
      num_tiles_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      tile_idx_q  <= tile_idx_d;
      num_tiles_q <= num_tiles_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign tile_idx = tile_idx_q;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed bench: dut A uses 4/2/3 segment lengths, dut B uses 4/0/0.
module tb_weight_load_sequencer;
  logic clk;
  logic rst_n;
  logic start_a, abort_a, busy_a, done_a;
  logic start_b, abort_b, busy_b, done_b;
  logic [15:0] num_a, num_b, tile_a, tile_b;
  int total, bad;

  weight_load_sequencer_if #(.DATA_WIDTH(16)) ifa ();
  weight_load_sequencer_if #(.DATA_WIDTH(16)) ifb ();

  weight_load_sequencer #(.DATA_WIDTH(16), .FILTER_LEN(4), .BIAS_LEN(2), .NORM_LEN(3), .TILE_W(16)) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .start(start_a), .abort(abort_a), .num_tiles(num_a),
    .busy(busy_a), .done(done_a), .tile_idx(tile_a), .wif(ifa.master));

  weight_load_sequencer #(.DATA_WIDTH(16), .FILTER_LEN(4), .BIAS_LEN(0), .NORM_LEN(0), .TILE_W(16)) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .start(start_b), .abort(abort_b), .num_tiles(num_b),
    .busy(busy_b), .done(done_b), .tile_idx(tile_b), .wif(ifb.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Onehot {norm,bias,filter} destination of beat k in a 9-beat A tile.
  function automatic logic [2:0] dest_a(input int k);
    int m;
    m = k % 9;
    if (m < 4) return 3'b001;
    if (m < 6) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] vld_a();
    return {ifa.normalization_params_tvalid, ifa.bias_stream_tvalid, ifa.filter_weights_tvalid};
  endfunction

  function automatic logic [2:0] vld_b();
    return {ifb.normalization_params_tvalid, ifb.bias_stream_tvalid, ifb.filter_weights_tvalid};
  endfunction

  // Checks a presented beat k on A (inputs already driven and settled).
  task automatic chk_beat_a(input int k, input int t);
    logic [15:0] d;
    chk($sformatf("a_dest[%0d]", k), 32'(vld_a()), 32'(dest_a(k)));
    chk($sformatf("a_tready[%0d]", k), 32'(ifa.s_axis_wsrc_tready), 32'd1);
    chk($sformatf("a_busy[%0d]", k), 32'(busy_a), 32'd1);
    chk($sformatf("a_tile[%0d]", k), 32'(tile_a), 32'(t));
    case (dest_a(k))
      3'b001:  d = ifa.filter_weights_tdata;
      3'b010:  d = ifa.bias_stream_tdata;
      default: d = ifa.normalization_params_tdata;
    endcase
    chk($sformatf("a_data[%0d]", k), 32'(d), 32'h100 + 32'(k));
  endtask

  task automatic beat_a(input int k, input int t);
    @(negedge clk);
    ifa.s_axis_wsrc_tdata  = 16'h100 + 16'(k);
    ifa.s_axis_wsrc_tvalid = 1'b1;
    #1;
    chk_beat_a(k, t);
  endtask

  task automatic go_a(input logic [15:0] n);
    @(negedge clk);
    start_a = 1'b1;
    num_a   = n;
    #1;
    chk("a_idle_tready", 32'(ifa.s_axis_wsrc_tready), 32'd0);
    chk("a_idle_busy", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic fin_a();
    @(negedge clk);
    ifa.s_axis_wsrc_tvalid = 1'b0;
    #1;
    chk("a_done_hi", 32'(done_a), 32'd1);
    chk("a_done_busy", 32'(busy_a), 32'd0);
    chk("a_done_tready", 32'(ifa.s_axis_wsrc_tready), 32'd0);
    @(negedge clk);
    #1;
    chk("a_done_lo", 32'(done_a), 32'd0);
  endtask

  initial begin
    int k, cyc, stalls, gap;
    total = 0; bad = 0;
    rst_n = 1'b0;
    start_a = 0; abort_a = 0; num_a = 0;
    start_b = 0; abort_b = 0; num_b = 0;
    ifa.s_axis_wsrc_tdata = 0; ifa.s_axis_wsrc_tvalid = 0;
    ifa.filter_weights_tready = 1; ifa.bias_stream_tready = 1; ifa.normalization_params_tready = 1;
    ifb.s_axis_wsrc_tdata = 0; ifb.s_axis_wsrc_tvalid = 0;
    ifb.filter_weights_tready = 1; ifb.bias_stream_tready = 1; ifb.normalization_params_tready = 1;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_tile", 32'(tile_a), 32'd0);
    chk("rst_tready", 32'(ifa.s_axis_wsrc_tready), 32'd0);
    chk("rst_vld", 32'(vld_a()), 32'd0);
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic run: 2 tiles, no stalls; busy only on the 18 beat cycles
    go_a(2);
    for (int i = 0; i < 18; i++) beat_a(i, i / 9);
    fin_a();

    // Backpressure on bias plus one source gap in tile 1
    go_a(2);
    k = 0; cyc = 0; stalls = 0; gap = 0;
    while (k < 18 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      ifa.s_axis_wsrc_tdata = 16'h100 + 16'(k);
      if (dest_a(k) == 3'b010 && stalls < 5) begin
        ifa.bias_stream_tready = 1'b0;
        ifa.s_axis_wsrc_tvalid = 1'b1;
        #1;
        chk("bp_src_tready", 32'(ifa.s_axis_wsrc_tready), 32'd0);
        chk("bp_bias_vld", 32'(vld_a()), 32'b010);
        stalls++;
      end else if (k == 10 && gap == 0) begin
        ifa.bias_stream_tready = 1'b1;
        ifa.s_axis_wsrc_tvalid = 1'b0;
        #1;
        chk("gap_vld", 32'(vld_a()), 32'd0);
        chk("gap_busy", 32'(busy_a), 32'd1);
        gap = 1;
      end else begin
        ifa.bias_stream_tready = 1'b1;
        ifa.s_axis_wsrc_tvalid = 1'b1;
        #1;
        chk_beat_a(k, k / 9);
        k++;
      end
    end
    chk("bp_beats", 32'(k), 32'd18);
    fin_a();

    // Zero-length bias/norm on B: 3 tiles of 4 filter beats
    @(negedge clk);
    start_b = 1'b1; num_b = 3;
    @(posedge clk);
    #1 start_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ifb.s_axis_wsrc_tdata  = 16'h200 + 16'(i);
      ifb.s_axis_wsrc_tvalid = 1'b1;
      #1;
      chk($sformatf("b_vld[%0d]", i), 32'(vld_b()), 32'b001);
      chk($sformatf("b_tile[%0d]", i), 32'(tile_b), 32'(i / 4));
      chk($sformatf("b_data[%0d]", i), 32'(ifb.filter_weights_tdata), 32'h200 + 32'(i));
    end
    @(negedge clk);
    ifb.s_axis_wsrc_tvalid = 1'b0;
    #1;
    chk("b_done_hi", 32'(done_b), 32'd1);
    chk("b_done_busy", 32'(busy_b), 32'd0);
    chk("b_done_tile", 32'(tile_b), 32'd2);

    // num_tiles=0: straight to done, nothing accepted
    ifa.s_axis_wsrc_tvalid = 1'b1;
    go_a(0);
    @(negedge clk);
    #1;
    chk("z_done", 32'(done_a), 32'd1);
    chk("z_busy", 32'(busy_a), 32'd0);
    chk("z_tready", 32'(ifa.s_axis_wsrc_tready), 32'd0);
    chk("z_vld", 32'(vld_a()), 32'd0);
    @(negedge clk);
    #1;
    chk("z_done_lo", 32'(done_a), 32'd0);
    ifa.s_axis_wsrc_tvalid = 1'b0;

    // Abort after 5 beats, then a fresh 1-tile run
    go_a(2);
    for (int i = 0; i < 5; i++) beat_a(i, 0);
    @(negedge clk);
    ifa.s_axis_wsrc_tdata = 16'h105; ifa.s_axis_wsrc_tvalid = 1'b1; abort_a = 1'b1;
    #1;
    chk("ab_cycle_vld", 32'(vld_a()), 32'b010);
    chk("ab_cycle_tready", 32'(ifa.s_axis_wsrc_tready), 32'd1);
    @(posedge clk);
    #1 abort_a = 1'b0;
    @(negedge clk);
    #1;
    chk("ab_busy", 32'(busy_a), 32'd0);
    chk("ab_done", 32'(done_a), 32'd0);
    chk("ab_tready", 32'(ifa.s_axis_wsrc_tready), 32'd0);
    ifa.s_axis_wsrc_tvalid = 1'b0;
    go_a(1);
    for (int i = 0; i < 9; i++) beat_a(i, 0);
    fin_a();

    // Async reset mid-BIAS of tile 1
    go_a(2);
    for (int i = 0; i < 13; i++) beat_a(i, i / 9);
    @(negedge clk);
    ifa.s_axis_wsrc_tdata = 16'h10d; ifa.s_axis_wsrc_tvalid = 1'b1;
    #1;
    chk("mr_tile_pre", 32'(tile_a), 32'd1);
    chk("mr_vld_pre", 32'(vld_a()), 32'b010);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy_a), 32'd0);
    chk("mr_tile", 32'(tile_a), 32'd0);
    chk("mr_tready", 32'(ifa.s_axis_wsrc_tready), 32'd0);
    chk("mr_vld", 32'(vld_a()), 32'd0);
    chk("mr_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ifa.s_axis_wsrc_tvalid = 1'b0;
    go_a(1);
    for (int i = 0; i < 9; i++) beat_a(i, 0);
    fin_a();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/weight_load_sequencer.md
Name: weight_load_sequencer

Overview:
- Splits one packed weight source stream (from DMA) into the three weight interfaces of the convolution kernel: filter_weights, bias_stream and normalization_params.
- For every output tile it sends a fixed-length burst to each interface in the order filter, bias, norm, and repeats this for a run-time number of tiles.
- Sits between the weight DMA and the kernel's WEIGHT-pragma interfaces; provides start/busy/done control for the host sequencer.

Parameters:
- DATA_WIDTH, 16, width of all weight tdata buses (source and destinations).
- FILTER_LEN, 36, beats sent to filter_weights per tile; must be >= 1.
- BIAS_LEN, 4, beats sent to bias_stream per tile; 0 means the segment is skipped.
- NORM_LEN, 8, beats sent to normalization_params per tile; 0 means the segment is skipped.
- TILE_W, 16, width of the tile count and tile index.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run. Ignored unless IDLE.
- abort  in  1  one-cycle pulse; cancels the current run.
- num_tiles  in  TILE_W  number of tiles; latched on an accepted start.
- busy  out  1  high while in FILTER, BIAS or NORM.
- done  out  1  one-cycle pulse when the run completes.
- tile_idx  out  TILE_W  index of the tile currently being sent.
- s_axis_wsrc_tdata  in  DATA_WIDTH  packed weight source data.
- s_axis_wsrc_tvalid  in  1  source valid.
- s_axis_wsrc_tready  out  1  source ready.
- filter_weights_tdata/tvalid/tready  out/out/in  DATA_WIDTH/1/1  filter weight stream.
- bias_stream_tdata/tvalid/tready  out/out/in  DATA_WIDTH/1/1  bias stream.
- normalization_params_tdata/tvalid/tready  out/out/in  DATA_WIDTH/1/1  normalization parameter stream.

Behaviour:
- Reset (asynchronous, ap_rst_n=0):
  - state=IDLE; beat_cnt=0; tile_idx=0; num_tiles_q=0.
  - busy=0, done=0, s_axis_wsrc_tready=0, all destination tvalid=0.
- FSM states: IDLE, FILTER, BIAS, NORM, DONE.
- IDLE:
  - start=1 latches num_tiles into num_tiles_q and clears tile_idx and beat_cnt.
  - If num_tiles=0, go to DONE; otherwise go to FILTER.
- Routing (combinational, zero latency, no buffering):
  - In state X, the selected destination gets tvalid = s_axis_wsrc_tvalid and tdata = s_axis_wsrc_tdata.
  - s_axis_wsrc_tready = selected destination tready.
  - Non-selected destinations have tvalid=0. All destination tdata buses carry s_axis_wsrc_tdata (don't-care when tvalid=0).
  - In IDLE and DONE, s_axis_wsrc_tready=0 and all tvalid=0.
- Beat counting:
  - A beat is a cycle with s_axis_wsrc_tvalid & s_axis_wsrc_tready.
  - beat_cnt increments on each beat. On the last beat of a segment (beat_cnt==LEN-1), beat_cnt clears and the state advances on the next edge.
- Segment order within a tile: FILTER -> BIAS -> NORM.
  - A segment whose LEN=0 is skipped in the same transition, e.g. FILTER goes straight to NORM when BIAS_LEN=0, or straight to tile end when both BIAS_LEN and NORM_LEN are 0.
- Tile end (last beat of the last non-empty segment):
  - If tile_idx==num_tiles_q-1, go to DONE.
  - Otherwise tile_idx increments and the state returns to FILTER.
- DONE: done=1 for exactly one cycle, then IDLE. tile_idx holds its final value until the next start.
- busy = state in {FILTER, BIAS, NORM}. busy falls in the same cycle that done rises.
- Source stall (tvalid=0) or destination backpressure (tready=0): state and counters hold, and no beat is counted.
- abort=1 in any state other than IDLE:
  - Next cycle: state=IDLE, beat_cnt=0, no done pulse.
  - tile_idx holds (it is debug-visible).
  - A beat presented in the abort cycle still transfers, because routing is combinational, but it is not counted.
- Start while busy or in DONE is ignored. abort in IDLE is a no-op.
- If start and abort are both asserted in IDLE, start wins.
- Reset asserted mid-run returns immediately to the reset values; no partial-tile recovery.
- Counter width: beat_cnt is wide enough for max(FILTER_LEN, BIAS_LEN, NORM_LEN); it never wraps because it clears at LEN-1.

Test Plan:
- Basic run: FILTER_LEN=4, BIAS_LEN=2, NORM_LEN=3, num_tiles=2, source always valid, all tready=1 -> filter gets beats 0-3, bias 4-5, norm 6-8, filter 9-12, bias 13-14, norm 15-17; tile_idx changes 0->1 after beat 8; done pulses one cycle after beat 17; busy is high for exactly 18 cycles.
- Backpressure: same config, bias_stream_tready held low for 5 cycles during BIAS -> s_axis_wsrc_tready=0 for those cycles, no beats lost or duplicated, and the order of all 18 data values is preserved.
- Zero-length segments: BIAS_LEN=0, NORM_LEN=0, num_tiles=3 -> only filter_weights receives data (12 beats); bias and norm tvalid stay 0 throughout; done pulses after the 12th beat.
- num_tiles=0: start -> busy never rises; done pulses on the cycle after start; no source beats are accepted.
- Abort: abort pulsed after beat 5 of tile 0 -> state returns to IDLE, no done pulse, tready=0; a fresh start with num_tiles=1 then delivers a full 9-beat tile starting at filter.
- Reset mid-run: ap_rst_n asserted asynchronously mid-BIAS -> all outputs take their reset values without waiting for a clock edge; after release, start runs normally.
